// File: rtl/div32.sv
// div32: sequential unsigned 64/32 restoring divider.
// Produces one quotient bit per clock. The dividend register shifts out
// dividend bits at the top and shifts quotient bits in at the bottom, so after
// 64 steps it holds the full 64-bit quotient.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; result outputs hold the last completion
// S_RUN  | 64 restoring-division steps, MSB first; cnt_q counts down to 0
module div32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] A64,
    input  logic [31:0] B,
    output logic [63:0] OUT64,
    output logic        busy,
    output logic        done,
    output logic        dz,
    output logic        ovf
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] dvd_q, dvd_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] b_q, b_d;
    logic [63:0] out_q, out_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;

    logic [32:0] rem_sh;
    logic [33:0] trial;
    logic        qbit;
    logic [32:0] rem_nx;
    logic [63:0] quo_nx;

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
    always_comb begin
        rem_sh = {rem_q[31:0], dvd_q[63]};
        trial  = {1'b0, rem_sh} - {2'b00, b_q};
        qbit   = ~trial[33];
        rem_nx = qbit ? trial[32:0] : rem_sh;
        quo_nx = {dvd_q[62:0], qbit};
    end

    // Next-state, datapath load/step and completion logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        b_d     = b_q;
        out_d   = out_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d   = A64;
                    b_d     = B;
                    rem_d   = '0;
                    cnt_d   = 6'd63;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                dvd_d = quo_nx;
                rem_d = rem_nx;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (b_q == 32'd0) begin
                        // With a zero divisor every trial succeeds, so the
                        // remainder register ends up holding A64[31:0].
                        out_d = {rem_nx[31:0], 32'hFFFF_FFFF};
                        dz_d  = 1'b1;
                        ovf_d = 1'b0;
                    end else begin
                        out_d = {rem_nx[31:0], quo_nx[31:0]};
                        dz_d  = 1'b0;
                        ovf_d = |quo_nx[63:32];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            b_q     <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            b_q     <= b_d;
            out_q   <= out_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign OUT64 = out_q;
    assign busy  = (state_q == S_RUN);
    assign done  = done_q;
    assign dz    = dz_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_div32.sv
// tb_div32: directed and swept checks of the div32 sequential divider.
module tb_div32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] A64;
    logic [31:0] B;
    logic [63:0] OUT64;
    logic        busy;
    logic        done;
    logic        dz;
    logic        ovf;

    int nvec = 0;
    int nerr = 0;

    div32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A64   (A64),
        .B     (B),
        .OUT64 (OUT64),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a start from the current time (just after an edge), wait for done.
    task automatic run_div(input logic [63:0] a, input logic [31:0] b);
        int cyc;
        A64   = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
        end
        chk("latency", 64'(cyc), 64'd64);
        chk("busy_at_done", 64'(busy), 64'd0);
    endtask

    // Reference: compare the latched result against native 64-bit division.
    task automatic check_res(input logic [63:0] a, input logic [31:0] b);
        logic [63:0] q;
        logic [63:0] r;
        if (b == 32'd0) begin
            chk("out_dz", OUT64, {a[31:0], 32'hFFFF_FFFF});
            chk("dz_flag", 64'(dz), 64'd1);
            chk("ovf_dz", 64'(ovf), 64'd0);
        end else begin
            q = a / {32'd0, b};
            r = a % {32'd0, b};
            chk("out", OUT64, {r[31:0], q[31:0]});
            chk("dz", 64'(dz), 64'd0);
            chk("ovf", 64'(ovf), 64'(q[63:32] != 32'd0));
            if (q[63:32] == 32'd0)
                chk("identity", {32'd0, OUT64[31:0]} * {32'd0, b} + {32'd0, OUT64[63:32]}, a);
        end
    endtask

    logic [63:0] ra;
    logic [31:0] rb;
    int          ndone;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        A64   = '0;
        B     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", OUT64, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz", 64'(dz), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with hand-computed results, issued back to back.
        run_div(64'd5106514152, 32'd5115);
        chk("v1_out", OUT64, {32'd5052, 32'd998340});
        chk("v1_dz", 64'(dz), 64'd0);
        chk("v1_ovf", 64'(ovf), 64'd0);
        run_div(64'd100, 32'd7);
        chk("v2_out", OUT64, {32'd2, 32'd14});
        run_div(64'h0000_0000_FFFF_FFFF, 32'd1);
        chk("v3_out", OUT64, {32'd0, 32'hFFFF_FFFF});
        chk("v3_ovf", 64'(ovf), 64'd0);
        run_div(64'h0000_0001_0000_0000, 32'd1);
        chk("v4_out", OUT64, 64'd0);
        chk("v4_ovf", 64'(ovf), 64'd1);
        chk("v4_dz", 64'(dz), 64'd0);
        run_div(64'h0000_0000_0000_1234, 32'd0);
        chk("v5_out", OUT64, {32'h0000_1234, 32'hFFFF_FFFF});
        chk("v5_dz", 64'(dz), 64'd1);
        chk("v5_ovf", 64'(ovf), 64'd0);

        // Start pulses during RUN with other operands must be ignored.
        A64   = 64'd1000;
        B     = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        A64   = 64'd77;
        B     = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("held_mid_run", OUT64, {32'h0000_1234, 32'hFFFF_FFFF});
        repeat (20) @(posedge clk);
        #1;
        A64   = 64'd9;
        B     = 32'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("ign_ndone", 64'(ndone), 64'd1);
        chk("ign_out", OUT64, {32'd1, 32'd333});

        // Asynchronous reset at cycle 30 of a division.
        A64   = 64'd123456789;
        B     = 32'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_out", OUT64, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ndone = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        chk("arst_no_done", 64'(ndone), 64'd0);
        run_div(64'd123456789, 32'd10);
        chk("arst_restart", OUT64, {32'd9, 32'd12345678});

        // Operand sweep across full-range, non-overflowing, zero and B > A cases.
        for (int i = 0; i < 1000; i++) begin
            case (i % 5)
                0: begin
                    rb = $urandom;
                    ra = {$urandom, $urandom};
                end
                1: begin
                    rb = $urandom | 32'd1;
                    ra = {32'($urandom % rb), $urandom};
                end
                2: begin
                    rb = 32'd0;
                    ra = {$urandom, $urandom};
                end
                3: begin
                    rb = $urandom | 32'h8000_0000;
                    ra = {32'd0, 32'($urandom % rb)};
                end
                default: begin
                    rb = 32'($urandom_range(1, 255));
                    ra = {32'd0, $urandom};
                end
            endcase
            run_div(ra, rb);
            check_res(ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
